// File: rtl/conbus_pkg.sv
// Shared definitions for the Wishbone interconnect arbiter: master count,
// cycle-type encodings, master index type and a one-hot decode helper.
package conbus_pkg;

  localparam int N_MASTERS = 6;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef logic [2:0] mst_idx_t;

  function automatic logic [N_MASTERS-1:0] idx_to_onehot(input mst_idx_t idx);
    logic [N_MASTERS-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      oh[i] = (idx == mst_idx_t'(i));
    end
    return oh;
  endfunction

  // Only classic cycles and end-of-burst beats may end an ownership quantum.
  function automatic logic is_boundary_cti(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/conbus_rr_pick.sv
// Rotating-priority encoder: returns the first requester found scanning
// upward from start_i (optionally skipping start_i itself), modulo N_MASTERS.
module conbus_rr_pick
  import conbus_pkg::*;
(
  input  logic [N_MASTERS-1:0] req_i,
  input  mst_idx_t             start_i,
  input  logic                 excl_start_i,
  output logic                 valid_o,
  output mst_idx_t             idx_o
);

  int pos;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = start_i;
    pos     = 0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      pos = (int'(start_i) + k) % N_MASTERS;
      if (!(excl_start_i && (k == 0)) && req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = mst_idx_t'(pos);
      end
    end
  end

endmodule

// File: rtl/conbus_wrr_arb.sv
// Weighted round-robin owner scheduler for the shared Wishbone bus, with a
// strobe-without-ack watchdog that reports (but never breaks) stuck transfers.
module conbus_wrr_arb
  import conbus_pkg::*;
#(
  parameter int QW        = 4,
  parameter int WD_CYCLES = 1024
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [N_MASTERS-1:0]    req,
  input  logic                    bus_stb,
  input  logic                    bus_ack,
  input  logic [2:0]              bus_cti,
  input  logic [N_MASTERS*QW-1:0] weight,
  output logic [N_MASTERS-1:0]    gnt,
  output logic                    wd_timeout,
  output logic [2:0]              wd_master
);

  localparam int             WDW    = $clog2(WD_CYCLES);
  localparam logic [WDW-1:0] WD_LIM = WDW'(WD_CYCLES - 1);

  // A programmed weight of zero still grants one transfer.
  function automatic logic [QW-1:0] quantum(input logic [N_MASTERS*QW-1:0] w,
                                            input mst_idx_t idx);
    logic [QW-1:0] q;
    q = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (idx == mst_idx_t'(i)) q = w[i*QW +: QW];
    end
    return (q == '0) ? QW'(1) : q;
  endfunction

  mst_idx_t             owner_q, owner_d;
  logic [N_MASTERS-1:0] gnt_q;
  logic [QW-1:0]        credit_q, credit_d, credit_dec;
  logic [WDW-1:0]       wd_cnt_q, wd_cnt_d;
  logic [2:0]           wd_master_q, wd_master_d;

  logic     owner_req, counted, boundary, rel_own, preempt, owner_change, wd_fire;
  logic     pick_valid;
  mst_idx_t pick_idx;

  conbus_rr_pick u_pick (
    .req_i        (req),
    .start_i      (owner_q),
    .excl_start_i (1'b1),
    .valid_o      (pick_valid),
    .idx_o        (pick_idx)
  );

  always_comb begin
    owner_req  = |(req & gnt_q);
    counted    = bus_stb & bus_ack & owner_req;
    boundary   = counted & is_boundary_cti(bus_cti);
    credit_dec = (counted && (credit_q != '0)) ? credit_q - 1'b1 : credit_q;
    rel_own    = !owner_req;
    preempt    = boundary && (credit_dec == '0) && pick_valid;

    owner_d  = owner_q;
    credit_d = credit_dec;
    // Release wins over exhaustion; a lone releasing owner parks and reloads.
    if (rel_own) begin
      owner_d  = pick_valid ? pick_idx : owner_q;
      credit_d = quantum(weight, owner_d);
    end else if (preempt) begin
      owner_d  = pick_idx;
      credit_d = quantum(weight, pick_idx);
    end
    owner_change = (owner_d != owner_q);

    wd_fire = (wd_cnt_q == WD_LIM);
    if (wd_fire || owner_change || !bus_stb || bus_ack) begin
      wd_cnt_d = '0;
    end else begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    wd_master_d = wd_fire ? owner_q : wd_master_q;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      owner_q     <= '0;
      gnt_q       <= idx_to_onehot('0);
      credit_q    <= quantum(weight, '0);
      wd_cnt_q    <= '0;
      wd_master_q <= '0;
    end else begin
      owner_q     <= owner_d;
      gnt_q       <= idx_to_onehot(owner_d);
      credit_q    <= credit_d;
      wd_cnt_q    <= wd_cnt_d;
      wd_master_q <= wd_master_d;
    end
  end

  assign gnt        = gnt_q;
  assign wd_timeout = wd_fire;
  assign wd_master  = wd_master_q;

endmodule

// File: tb/tb_conbus_wrr_arb.sv
// Vector table for arbitration/burst/reset behaviour plus hand-written
// watchdog sequences for conbus_wrr_arb (QW=4, WD_CYCLES=16).
module tb_conbus_wrr_arb;
  import conbus_pkg::*;

  localparam logic [23:0] W_ONE  = 24'h111111;
  localparam logic [23:0] W_WGT  = 24'h111113;  // weight[0]=3
  localparam logic [23:0] W_ZERO = 24'h111103;  // weight[1]=0
  localparam logic [23:0] W_RST  = 24'h211103;  // weight[5]=2

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [5:0]  req;
  logic        bus_stb, bus_ack;
  logic [2:0]  bus_cti;
  logic [23:0] weight;
  logic [5:0]  gnt;
  logic        wd_timeout;
  logic [2:0]  wd_master;

  conbus_wrr_arb #(.QW(4), .WD_CYCLES(16)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req        (req),
    .bus_stb    (bus_stb),
    .bus_ack    (bus_ack),
    .bus_cti    (bus_cti),
    .weight     (weight),
    .gnt        (gnt),
    .wd_timeout (wd_timeout),
    .wd_master  (wd_master)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        rst_n;
    logic [23:0] wt;
    logic [5:0]  req;
    logic        stb;
    logic        ack;
    logic [2:0]  cti;
    logic [5:0]  exp_gnt;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic add(input logic r, input logic [23:0] w, input logic [5:0] rq,
                     input logic s, input logic a, input logic [2:0] c,
                     input logic [5:0] e);
    vec_t v;
    v.rst_n = r; v.wt = w; v.req = rq; v.stb = s; v.ack = a; v.cti = c; v.exp_gnt = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n = 1'b0; req = '0; bus_stb = 1'b0; bus_ack = 1'b0;
    bus_cti = CTI_CLASSIC; weight = W_ONE;

    // reset and park, then master 3 from idle
    add(0, W_ONE,  6'b000000, 0, 0, CTI_CLASSIC, 6'b000001);
    add(0, W_ONE,  6'b000000, 0, 0, CTI_CLASSIC, 6'b000001);
    add(1, W_ONE,  6'b000000, 0, 0, CTI_CLASSIC, 6'b000001);
    add(1, W_ONE,  6'b001000, 0, 0, CTI_CLASSIC, 6'b001000);
    // equal weights, everyone requesting
    add(1, W_ONE,  6'b111111, 1, 1, CTI_CLASSIC, 6'b010000);
    add(1, W_ONE,  6'b111111, 1, 1, CTI_CLASSIC, 6'b100000);
    add(1, W_ONE,  6'b111111, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_ONE,  6'b111111, 1, 1, CTI_CLASSIC, 6'b000010);
    add(1, W_ONE,  6'b111111, 1, 1, CTI_CLASSIC, 6'b000100);
    add(1, W_ONE,  6'b111111, 1, 1, CTI_CLASSIC, 6'b001000);
    add(1, W_ONE,  6'b111111, 1, 1, CTI_CLASSIC, 6'b010000);
    // weight 3:1 between masters 0 and 1
    add(1, W_WGT,  6'b000011, 0, 0, CTI_CLASSIC, 6'b000001);
    add(1, W_WGT,  6'b000011, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_WGT,  6'b000011, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_WGT,  6'b000011, 1, 1, CTI_CLASSIC, 6'b000010);
    add(1, W_WGT,  6'b000011, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_WGT,  6'b000011, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_WGT,  6'b000011, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_WGT,  6'b000011, 1, 1, CTI_CLASSIC, 6'b000010);
    // zero weight on master 1 acts as one
    add(1, W_ZERO, 6'b000011, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_ZERO, 6'b000011, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_ZERO, 6'b000011, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_ZERO, 6'b000011, 1, 1, CTI_CLASSIC, 6'b000010);
    add(1, W_ZERO, 6'b000011, 1, 1, CTI_CLASSIC, 6'b000001);
    // master 2 burst with master 4 waiting, one wait state mid-burst
    add(1, W_ZERO, 6'b010100, 0, 0, CTI_CLASSIC, 6'b000100);
    add(1, W_ZERO, 6'b010100, 1, 1, CTI_INCR,    6'b000100);
    add(1, W_ZERO, 6'b010100, 1, 0, CTI_INCR,    6'b000100);
    add(1, W_ZERO, 6'b010100, 1, 1, CTI_INCR,    6'b000100);
    add(1, W_ZERO, 6'b010100, 1, 1, CTI_INCR,    6'b000100);
    add(1, W_ZERO, 6'b010100, 1, 1, CTI_EOB,     6'b010000);
    add(1, W_ZERO, 6'b010100, 1, 1, CTI_CLASSIC, 6'b000100);
    // release picks the next index upward (4 before 0), then park
    add(1, W_ZERO, 6'b010001, 0, 0, CTI_CLASSIC, 6'b010000);
    add(1, W_ZERO, 6'b000000, 0, 0, CTI_CLASSIC, 6'b010000);
    // reset in the middle of master 5's burst; credit reloads from weight[0]=3
    add(1, W_RST,  6'b100000, 0, 0, CTI_CLASSIC, 6'b100000);
    add(1, W_RST,  6'b100000, 1, 1, CTI_INCR,    6'b100000);
    add(0, W_RST,  6'b100000, 1, 1, CTI_INCR,    6'b000001);
    add(1, W_RST,  6'b100001, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_RST,  6'b100001, 1, 1, CTI_CLASSIC, 6'b000001);
    add(1, W_RST,  6'b100001, 1, 1, CTI_CLASSIC, 6'b100000);

    for (int i = 0; i < tbl.size(); i++) begin
      sys_rst_n = tbl[i].rst_n;
      weight    = tbl[i].wt;
      req       = tbl[i].req;
      bus_stb   = tbl[i].stb;
      bus_ack   = tbl[i].ack;
      bus_cti   = tbl[i].cti;
      exp_q.push_back(tbl[i].exp_gnt);
      tick();
      check($sformatf("gnt vec %0d", i), gnt, exp_q.pop_front());
      check($sformatf("wd_timeout vec %0d", i), wd_timeout, 0);
      if (i == 1) check("wd_master after reset", wd_master, 0);
    end

    // continuous stall by master 5: pulses in stall cycles 15 and 31
    req = 6'b100000; bus_stb = 1'b0; bus_ack = 1'b0; bus_cti = CTI_CLASSIC;
    tick();
    bus_stb = 1'b1;
    for (int k = 0; k < 32; k++) begin
      check($sformatf("wd stall cycle %0d", k), wd_timeout, (k == 15 || k == 31));
      if (k == 16) check("wd_master latched", wd_master, 5);
      tick();
    end
    check("gnt kept through timeouts", gnt, 6'b100000);

    // an ack in cycle 10 restarts the count; next pulse lands in cycle 26
    bus_stb = 1'b0;
    tick();
    bus_stb = 1'b1;
    for (int k = 0; k < 27; k++) begin
      bus_ack = (k == 10);
      #1;
      check($sformatf("wd ack-restart cycle %0d", k), wd_timeout, (k == 26));
      tick();
    end
    bus_stb = 1'b0; bus_ack = 1'b0;
    tick();
    check("wd_master after restart", wd_master, 5);
    check("gnt after watchdog", gnt, 6'b100000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conbus_wrr_arb.md
# conbus_wrr_arb

Weighted round-robin arbiter and bus scheduler for the shared Wishbone interconnect. It drives the one-hot grant vector that selects which of six masters owns the interconnect's internal shared bus. Each master gets a programmable quantum of completed transfers before a waiting master can take over. It also runs a watchdog that flags transfers a slave never acknowledges. The block is a drop-in replacement for the existing simple arbiter, with extra inputs taken from the shared bus and from a CSR block.

## Interface

Parameters:

- N_MASTERS, 6, number of requesters; fixed at 6 by the interconnect.
- QW, 4, quantum width in bits; weight range 1..2^QW-1.
- WD_CYCLES, 1024, watchdog limit in cycles of strobe-without-ack; minimum 2.

Ports:

- sys_clk  in  1  system clock; all state updates on its rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- req  in  6  per-master cyc; bit i belongs to master i.
- bus_stb  in  1  stb of the currently muxed master (cyc & stb).
- bus_ack  in  1  OR of all slave acks.
- bus_cti  in  3  cti of the currently muxed master.
- weight  in  6*QW  per-master quantum; master i uses bits [i*QW +: QW]; value 0 is treated as 1.
- gnt  out  6  registered one-hot grant; never all-zero.
- wd_timeout  out  1  one-cycle pulse when the watchdog expires.
- wd_master  out  3  index of the owner at the last timeout; holds until the next timeout.

## Operation

- State: owner index (3 bits), credit counter (QW bits), watchdog counter (clog2(WD_CYCLES) bits).
- gnt is always the one-hot decode of owner.
- Counted transfer: a cycle with bus_stb & bus_ack & req[owner]. Each counted transfer decrements credit, saturating at 0.
- Transfer boundary: a counted transfer with bus_cti == 3'b000 (classic) or 3'b111 (end of burst). Credit exhaustion never switches the owner inside an incrementing burst (cti 3'b010).
- Handover conditions, evaluated every cycle:
  - Release: req[owner] == 0.
  - Preempt: a boundary transfer leaves credit == 0 (after its decrement) and some other req bit is high.
- Next owner on handover: the first requesting index scanning owner+1, owner+2, … modulo 6, excluding the current owner.
  - On a release with no other requester, owner is unchanged (park) and credit reloads.
- Reload: on every owner change or park reload, credit <= max(weight[new owner], 1), sampled in that cycle.
- A preempted master keeps cyc high and simply stalls. Its stb is masked because its gnt bit is low. It regains the bus on its next round-robin turn.
- Watchdog:
  - Counter increments while bus_stb & !bus_ack.
  - It clears on bus_ack, on !bus_stb, and on any owner change.
  - On reaching WD_CYCLES-1 it pulses wd_timeout, latches wd_master <= owner, and clears.
  - It only reports; ownership is unaffected.

## Timing

- Reset values: owner 0 (gnt = 6'b000001), credit = max(weight[0],1) sampled during reset, watchdog 0, wd_timeout 0, wd_master 0.
- Arbitration latency: the decision is combinational from req/bus_* in cycle N. gnt changes at the edge ending cycle N and is visible in cycle N+1. From idle-park, a new requester sees its grant 1 cycle after raising cyc.
- Simultaneous release and exhaustion: treated as release; same next-owner rule.
- A counted transfer in the same cycle as a handover is still attributed to the old owner; the new credit is not decremented.
- Weight changes take effect at the next reload only.
- Reset asserted mid-transfer: the next edge forces the reset values regardless of req/ack.
- wd_timeout is high for exactly 1 cycle per expiry. The earliest first pulse is in cycle WD_CYCLES-1 of a continuous stall.

## Structure

- Shared package conbus_pkg: N_MASTERS, CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111, and the master index type (3 bits).
- Sub-module conbus_rr_pick: combinational rotate-priority encoder.
  - Inputs: req (6), start index (3), and an exclude-start flag.
  - Outputs: a valid flag and the picked index (3).
- Everything else lives in the top-level: owner, credit and watchdog registers, handover logic, grant decode.

## Test plan

- Reset/park: hold sys_rst_n=0 for 2 cycles, then req=0 → gnt=000001, wd_timeout=0. Raise req[3] → gnt=001000 one cycle later.
- Round-robin fairness: weights all 1, req=111111, masters issue classic single transfers acked every cycle → gnt sequence 000001,000010,…,100000,000001.
- Weighting: weight[0]=3, weight[1]=1, req=000011, classic transfers → 3 acks for master 0, 1 for master 1, repeating.
- Burst protection: weight[2]=1, master 2 runs a 4-beat burst (cti 010,010,010,111) with req[4] high → no switch until after the 111 ack; gnt=010000 the next cycle.
- Watchdog: WD_CYCLES=16, bus_stb=1, no ack → one wd_timeout pulse every 16 cycles with wd_master = owner. An ack at cycle 10 → no pulse.
- Zero weight and reset mid-burst: weight[1]=0 behaves as 1. Asserting sys_rst_n=0 in the middle of master 5's burst → gnt=000001 and credit reloaded at the next edge.
